// File: rtl/mackerel_bus_timer_if.sv
// Mackerel 68000 bus-cycle signals between the CPU/decoder side and
// the DTACK/BERR timer.
interface mackerel_bus_timer_if;
  logic       AS;
  logic       ROMEN;
  logic       RAMEN;
  logic       MFPEN;
  logic       IACK;
  logic       DTACK_MFP;
  logic       DTACK;
  logic       BERR;
  logic [7:0] BERR_COUNT;

  modport master (
    output AS, ROMEN, RAMEN, MFPEN, IACK, DTACK_MFP,
    input  DTACK, BERR, BERR_COUNT
  );

  modport slave (
    input  AS, ROMEN, RAMEN, MFPEN, IACK, DTACK_MFP,
    output DTACK, BERR, BERR_COUNT
  );
endinterface

// File: rtl/mackerel_bus_timer.sv
// Mackerel bus timer: generates 68000 DTACK after per-device wait states
// and BERR on watchdog timeout, with a saturating bus-error counter.
module mackerel_bus_timer #(
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic                CLK,
  input  logic                RST,
  mackerel_bus_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, WAIT, ACK, ERR
  } state_t;

  typedef enum logic [1:0] {
    CY_NONE, CY_MEM, CY_MFP
  } cyc_t;

  state_t     r_state, w_state_nxt;
  cyc_t       r_cyc, w_cyc_nxt;
  logic [7:0] r_wait, w_wait_nxt;
  logic [7:0] r_wdog, w_wdog_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_armed, w_armed_nxt;
  logic       r_dtack;
  logic       r_berr;
  logic       w_ack;

  assign w_ack = (r_cyc == CY_MEM && r_wait == 8'd0) ||
                 (r_cyc == CY_MFP && !bus.DTACK_MFP);

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_wait_nxt  = r_wait;
    w_wdog_nxt  = r_wdog;
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        // a cycle starts only after an idle edge has seen AS high
        w_armed_nxt = bus.AS;
        if (!bus.AS && r_armed) begin
          w_state_nxt = WAIT;
          w_wdog_nxt  = 8'd1;
          w_armed_nxt = 1'b0;
          if (!bus.ROMEN) begin
            w_cyc_nxt  = CY_MEM;
            w_wait_nxt = 8'(ROM_WAIT);
          end else if (!bus.RAMEN) begin
            w_cyc_nxt  = CY_MEM;
            w_wait_nxt = 8'(RAM_WAIT);
          end else if (!bus.MFPEN || !bus.IACK) begin
            w_cyc_nxt  = CY_MFP;
            w_wait_nxt = 8'd0;
          end else begin
            w_cyc_nxt  = CY_NONE;
            w_wait_nxt = 8'd0;
          end
        end
      end
      WAIT: begin
        if (bus.AS) begin
          w_state_nxt = IDLE;
        end else if (w_ack) begin
          w_state_nxt = ACK;
        end else if (r_wdog == 8'(TIMEOUT)) begin
          w_state_nxt = ERR;
          if (r_cnt != 8'hFF) w_cnt_nxt = r_cnt + 8'd1;
        end else begin
          w_wdog_nxt = r_wdog + 8'd1;
          if (r_cyc == CY_MEM) w_wait_nxt = r_wait - 8'd1;
        end
      end
      ACK, ERR: begin
        if (bus.AS) w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cyc   <= CY_NONE;
      r_wait  <= 8'd0;
      r_wdog  <= 8'd0;
      r_cnt   <= 8'd0;
      r_armed <= 1'b0;
      r_dtack <= 1'b1;
      r_berr  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_wait  <= w_wait_nxt;
      r_wdog  <= w_wdog_nxt;
      r_cnt   <= w_cnt_nxt;
      r_armed <= w_armed_nxt;
      r_dtack <= (w_state_nxt != ACK);
      r_berr  <= (w_state_nxt != ERR);
    end
  end

  assign bus.DTACK      = r_dtack;
  assign bus.BERR       = r_berr;
  assign bus.BERR_COUNT = r_cnt;

endmodule

// File: tb/tb_mackerel_bus_timer.sv
// Bench for mackerel_bus_timer: vector table of bus cycles checked through
// a scoreboard queue, plus abort, mid-cycle reset and saturation sequences.
module tb_mackerel_bus_timer;
  localparam int TO = 64;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mackerel_bus_timer_if bus();

  mackerel_bus_timer #(
    .ROM_WAIT(2),
    .RAM_WAIT(0),
    .TIMEOUT (TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic romen;
    logic ramen;
    logic mfpen;
    logic iack;
    int   mfp_at;
    int   exp_edge;
    bit   exp_err;
  } vec_t;

  typedef struct {
    int edge_n;
    bit err;
    int cnt;
  } sb_t;

  sb_t  sb[$];
  vec_t vt[13];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic idle_gap();
    @(negedge CLK);
    bus.AS = 1'b1;
    bus.ROMEN = 1'b1;
    bus.RAMEN = 1'b1;
    bus.MFPEN = 1'b1;
    bus.IACK = 1'b1;
    bus.DTACK_MFP = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic run_cycle(input vec_t v, input string nm);
    sb_t e;
    sb_t got;
    bit  seen;
    e.edge_n = v.exp_edge;
    e.err    = v.exp_err;
    if (v.exp_err) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    e.cnt = exp_cnt;
    sb.push_back(e);
    idle_gap();
    bus.AS = 1'b0;
    bus.ROMEN = v.romen;
    bus.RAMEN = v.ramen;
    bus.MFPEN = v.mfpen;
    bus.IACK = v.iack;
    @(negedge CLK);
    // selects flip after the latch edge and must not matter
    bus.ROMEN = ~v.romen;
    bus.RAMEN = ~v.ramen;
    bus.MFPEN = ~v.mfpen;
    bus.IACK = ~v.iack;
    seen = 1'b0;
    got.edge_n = -1;
    got.err = 1'b0;
    for (int k = 0; k <= TO + 4; k++) begin
      if (k > 0) @(negedge CLK);
      if (!bus.DTACK || !bus.BERR) begin
        seen = 1'b1;
        got.edge_n = k;
        got.err = !bus.BERR;
        break;
      end
      if (k == v.mfp_at) bus.DTACK_MFP = 1'b0;
    end
    got.cnt = int'(bus.BERR_COUNT);
    e = sb.pop_front();
    chk({nm, " edge"}, got.edge_n, e.edge_n);
    chk({nm, " kind"}, int'(got.err), int'(e.err));
    chk({nm, " count"}, got.cnt, e.cnt);
    if (seen) begin
      repeat (2) @(negedge CLK);
      chk({nm, " held"}, int'({bus.DTACK, bus.BERR}),
          e.err ? 2 : 1);
    end
    bus.AS = 1'b1;
    @(negedge CLK);
    chk({nm, " release"}, int'({bus.DTACK, bus.BERR}), 3);
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, -1, 3, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, -1, 1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, -1, 1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, -1, 3, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, -1, 1, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5, 6, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 3, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, -1, TO, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, -1, TO, 1'b1};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 3, TO, 1'b1};
    vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, TO - 1, TO, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, TO, TO, 1'b1};

    bus.AS = 1'b1;
    bus.ROMEN = 1'b1;
    bus.RAMEN = 1'b1;
    bus.MFPEN = 1'b1;
    bus.IACK = 1'b1;
    bus.DTACK_MFP = 1'b1;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset strobes", int'({bus.DTACK, bus.BERR}), 3);
    chk("reset count", int'(bus.BERR_COUNT), 0);
    RST = 1'b1;

    foreach (vt[i]) run_cycle(vt[i], $sformatf("vec%0d", i));

    // aborted ROM cycle: AS rises one edge after it was sampled low
    idle_gap();
    bus.AS = 1'b0;
    bus.ROMEN = 1'b0;
    @(negedge CLK);
    bus.AS = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("abort quiet", int'({bus.DTACK, bus.BERR}), 3);
    end
    chk("abort count", int'(bus.BERR_COUNT), exp_cnt);

    // reset in WAIT of a ROM cycle, AS left low across release
    idle_gap();
    bus.AS = 1'b0;
    bus.ROMEN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    exp_cnt = 0;
    chk("midrst strobes", int'({bus.DTACK, bus.BERR}), 3);
    chk("midrst count", int'(bus.BERR_COUNT), 0);
    RST = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("midrst no ack", int'({bus.DTACK, bus.BERR}), 3);
    end
    run_cycle(vt[0], "after rst");

    for (int n = 0; n < 300; n++) run_cycle(vt[9], "sat");
    chk("sat final", int'(bus.BERR_COUNT), 255);
    run_cycle(vt[1], "post sat ram");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mackerel_bus_timer.md
MACKEREL_BUS_TIMER -- requirements
Module: mackerel_bus_timer

Interface
REQ-001 The block SHALL have parameter ROM_WAIT, default 2, meaning wait states inserted before DTACK for ROM cycles.
REQ-002 The block SHALL have parameter RAM_WAIT, default 0, meaning wait states inserted before DTACK for RAM cycles.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning cycles from AS sample to bus error; legal range 4..255 and greater than ROM_WAIT+2 and RAM_WAIT+2.
REQ-004 CLK  input  1  CPU clock; all state changes on rising edge.
REQ-005 RST  input  1  synchronous, active-low reset.
REQ-006 AS  input  1  68000 address strobe, active-low.
REQ-007 ROMEN  input  1  ROM chip select from the address decoder, active-low.
REQ-008 RAMEN  input  1  RAM chip select from the address decoder, active-low.
REQ-009 MFPEN  input  1  MFP chip select from the address decoder, active-low.
REQ-010 IACK  input  1  interrupt-acknowledge cycle indicator, active-low.
REQ-011 DTACK_MFP  input  1  MFP data acknowledge, active-low.
REQ-012 DTACK  output  1  registered CPU data acknowledge, active-low.
REQ-013 BERR  output  1  registered CPU bus error, active-low.
REQ-014 BERR_COUNT  output  8  saturating count of bus-error cycles since reset.

Function
REQ-015 The block SHALL implement states IDLE, WAIT, ACK, ERR; DTACK low only in ACK, BERR low only in ERR.
REQ-016 In IDLE, on an edge sampling AS low, the block SHALL enter WAIT, latch cycle type by priority ROMEN > RAMEN > MFPEN > IACK > none, load wait counter (ROM_WAIT, RAM_WAIT, or 0 for MFP/IACK/none) and load watchdog to 1.
REQ-017 Chip selects SHALL be latched only at IDLE->WAIT; changes during WAIT SHALL be ignored.
REQ-018 ROM/RAM cycles SHALL move WAIT->ACK on the edge where wait counter equals 0, else decrement; DTACK therefore goes low N+1 edges after the AS-sampling edge (N = wait parameter).
REQ-019 MFP and IACK cycles SHALL move WAIT->ACK on the edge DTACK_MFP is sampled low; DTACK low is delayed one edge from DTACK_MFP.
REQ-020 Unselected cycles (type none) SHALL never acknowledge and SHALL end only via timeout.
REQ-021 The watchdog SHALL increment each edge in WAIT; when watchdog equals TIMEOUT and no ack condition holds that edge, the block SHALL enter ERR.
REQ-022 If ack condition and timeout coincide on the same edge, ACK SHALL win and BERR SHALL not assert.
REQ-023 ACK and ERR SHALL be held until AS is sampled high, then return to IDLE with DTACK/BERR high on that same edge.
REQ-024 AS sampled high in WAIT (aborted cycle) SHALL return to IDLE without asserting DTACK or BERR.
REQ-025 A new cycle SHALL require at least one edge in IDLE with AS high; AS held low across ACK->IDLE SHALL not start a new cycle.
REQ-026 BERR_COUNT SHALL increment by 1 on each WAIT->ERR transition and saturate at 255.
REQ-027 Wait and watchdog counters SHALL be 8 bits; no wrap-around is permitted within legal parameter range.

Reset
REQ-028 With RST sampled low, the block SHALL enter IDLE, drive DTACK=1, BERR=1, BERR_COUNT=0, clear both counters, on the same edge.
REQ-029 RST asserted mid-cycle (WAIT, ACK or ERR) SHALL abort the cycle with no further DTACK/BERR assertion; after RST release a new cycle requires AS high then low.

Verification
REQ-030 Defaults, ROMEN=0, AS low sampled at edge 0 -> DTACK low after edge 3, released edge after AS high.
REQ-031 RAMEN=0, RAM_WAIT=0, AS low at edge 0 -> DTACK low after edge 1; back-to-back cycles each acknowledged.
REQ-032 MFPEN=0, DTACK_MFP low at edge 5 -> DTACK low after edge 6; DTACK_MFP never low -> BERR low at TIMEOUT, BERR_COUNT=1.
REQ-033 No select, AS low held -> BERR low at edge 64, held until AS high; repeat 300 times -> BERR_COUNT=255.
REQ-034 DTACK_MFP low on exactly the timeout edge -> DTACK low, BERR stays high, BERR_COUNT unchanged.
REQ-035 RST low while in WAIT of ROM cycle -> DTACK/BERR high next edge, BERR_COUNT=0, no acknowledge until fresh AS.
